// File: rtl/rfdc_sync_pkg.sv
// Shared definitions for the RFDC sync/reset controller.
//   Register byte offsets relative to BASE_ADDR.
//   Bit positions inside the NCO_CTRL and GEARBOX registers.
//   FSM state enum for the NCO reset sequencer.
package rfdc_sync_pkg;

  localparam logic [19:0] NCO_CTRL_OFS    = 20'h0;
  localparam logic [19:0] GEARBOX_OFS     = 20'h4;
  localparam logic [19:0] PULSE_WIDTH_OFS = 20'h8;

  localparam int unsigned START_BIT          = 0;
  localparam int unsigned BUSY_BIT           = 0;
  localparam int unsigned DONE_BIT           = 1;
  localparam int unsigned FAILED_BIT         = 8;
  localparam int unsigned SYSREF_WAIT_LSB    = 16;
  localparam int unsigned SYSREF_WAIT_EN_BIT = 24;
  localparam int unsigned DAC_REQ_LSB        = 16;

  localparam int unsigned PULSE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ASSERT,
    ST_RELEASE
  } seq_state_e;

endpackage

// File: rtl/rfdc_reset_pulse_gen.sv
// Gearbox reset pulse stretcher for one channel.
//   clk, rst : data clock, synchronous active-high reset
//   req      : one-cycle request; (re)loads the counter with width
//   width    : pulse lasts width+1 cycles
//   pulse    : reset output, high from the cycle after req
module rfdc_reset_pulse_gen
  import rfdc_sync_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [PULSE_CNT_W-1:0] width,
  output logic                   pulse
);

  logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   active_q, active_d;

  // A request while active simply reloads, so the pulse continues without a gap.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (req) begin
      cnt_d    = width;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign pulse = active_q;

endmodule

// File: rtl/rfdc_sync_sequencer.sv
// RFDC sync/reset controller behind a single CtrlPort slave.
//   clk, rst               : RFDC data clock, synchronous active-high reset
//   s_ctrlport_req_*       : CtrlPort request (wr, rd, 20-bit byte addr, 32-bit data)
//   s_ctrlport_resp_*      : registered one-cycle ack, status (always 0), read data
//   sysref_pulse           : one-cycle SYSREF strobe in clk domain
//   nco_reset              : NCO reset level driven by the sequencer FSM
//   adc_reset / dac_reset  : per-channel gearbox reset pulses
module rfdc_sync_sequencer
  import rfdc_sync_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int BASE_ADDR      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_ctrlport_req_wr,
  input  logic                    s_ctrlport_req_rd,
  input  logic [19:0]             s_ctrlport_req_addr,
  input  logic [31:0]             s_ctrlport_req_data,
  output logic                    s_ctrlport_resp_ack,
  output logic [1:0]              s_ctrlport_resp_status,
  output logic [31:0]             s_ctrlport_resp_data,
  input  logic                    sysref_pulse,
  output logic                    nco_reset,
  output logic [NUM_CHANNELS-1:0] adc_reset,
  output logic [NUM_CHANNELS-1:0] dac_reset
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [19:0]     BASE     = 20'(BASE_ADDR);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e              state_q, state_d;
  logic [7:0]              sysref_wait_q, sysref_wait_d;
  logic [7:0]              snap_q, snap_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    done_q, done_d;
  logic                    failed_q, failed_d;
  logic                    nco_q, nco_d;
  logic [PULSE_CNT_W-1:0]  pulse_width_q, pulse_width_d;
  logic                    ack_q, ack_d;
  logic [31:0]             resp_data_q, resp_data_d;

  logic                    sel_nco, sel_gb, sel_pw, decoded;
  logic                    start;
  logic [NUM_CHANNELS-1:0] adc_req, dac_req;
  logic [31:0]             rd_data;
  logic                    unused_req_data;

  assign unused_req_data = ^s_ctrlport_req_data;

  // CtrlPort decode, register writes and response
  always_comb begin
    sel_nco = (s_ctrlport_req_addr == BASE + NCO_CTRL_OFS);
    sel_gb  = (s_ctrlport_req_addr == BASE + GEARBOX_OFS);
    sel_pw  = (s_ctrlport_req_addr == BASE + PULSE_WIDTH_OFS);
    decoded = sel_nco | sel_gb | sel_pw;

    sysref_wait_d = sysref_wait_q;
    if (s_ctrlport_req_wr && sel_nco && s_ctrlport_req_data[SYSREF_WAIT_EN_BIT]) begin
      sysref_wait_d = s_ctrlport_req_data[SYSREF_WAIT_LSB +: 8];
    end
    pulse_width_d = pulse_width_q;
    if (s_ctrlport_req_wr && sel_pw) begin
      pulse_width_d = s_ctrlport_req_data[PULSE_CNT_W-1:0];
    end
    start   = s_ctrlport_req_wr && sel_nco && s_ctrlport_req_data[START_BIT];
    adc_req = (s_ctrlport_req_wr && sel_gb) ? s_ctrlport_req_data[NUM_CHANNELS-1:0] : '0;
    dac_req = (s_ctrlport_req_wr && sel_gb) ? s_ctrlport_req_data[DAC_REQ_LSB +: NUM_CHANNELS] : '0;

    rd_data = '0;
    if (sel_nco) begin
      rd_data[BUSY_BIT]                 = (state_q != ST_IDLE);
      rd_data[DONE_BIT]                 = done_q;
      rd_data[FAILED_BIT]               = failed_q;
      rd_data[SYSREF_WAIT_LSB +: 8]     = sysref_wait_q;
    end else if (sel_gb) begin
      rd_data[NUM_CHANNELS-1:0]         = adc_reset;
      rd_data[DAC_REQ_LSB +: NUM_CHANNELS] = dac_reset;
    end else if (sel_pw) begin
      rd_data[PULSE_CNT_W-1:0]          = pulse_width_q;
    end

    // Simultaneous rd+wr is treated as a write: single ack, no read data.
    ack_d       = (s_ctrlport_req_wr || s_ctrlport_req_rd) && decoded;
    resp_data_d = (s_ctrlport_req_rd && !s_ctrlport_req_wr && decoded) ? rd_data : '0;
  end

  // NCO reset sequencer
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    done_d   = done_q;
    failed_d = failed_q;
    nco_d    = nco_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ARM;
          snap_d   = sysref_wait_d;
          cnt_d    = '0;
          tmo_d    = '0;
          done_d   = 1'b0;
          failed_d = 1'b0;
        end
      end
      ST_ARM: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_LAST) begin
          failed_d = 1'b1;
          nco_d    = 1'b0;
          state_d  = ST_IDLE;
        end else if (sysref_pulse) begin
          if (cnt_q == snap_q) begin
            nco_d   = 1'b1;
            state_d = ST_ASSERT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ASSERT: begin
        tmo_d = tmo_q + 1'b1;
        // Completing SYSREF is checked first so it wins over a same-cycle timeout.
        if (sysref_pulse) begin
          nco_d   = 1'b0;
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          failed_d = 1'b1;
          nco_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sysref_wait_q <= '0;
      snap_q        <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      done_q        <= 1'b0;
      failed_q      <= 1'b0;
      nco_q         <= 1'b0;
      pulse_width_q <= '0;
      ack_q         <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      sysref_wait_q <= sysref_wait_d;
      snap_q        <= snap_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      done_q        <= done_d;
      failed_q      <= failed_d;
      nco_q         <= nco_d;
      pulse_width_q <= pulse_width_d;
      ack_q         <= ack_d;
      resp_data_q   <= resp_data_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    rfdc_reset_pulse_gen u_adc (
      .clk   (clk),
      .rst   (rst),
      .req   (adc_req[ch]),
      .width (pulse_width_q),
      .pulse (adc_reset[ch])
    );
    rfdc_reset_pulse_gen u_dac (
      .clk   (clk),
      .rst   (rst),
      .req   (dac_req[ch]),
      .width (pulse_width_q),
      .pulse (dac_reset[ch])
    );
  end

  assign nco_reset              = nco_q;
  assign s_ctrlport_resp_ack    = ack_q;
  assign s_ctrlport_resp_status = 2'b00;
  assign s_ctrlport_resp_data   = resp_data_q;

endmodule

// File: tb/tb_rfdc_sync_sequencer.sv
// Directed bench for rfdc_sync_sequencer (4 channels, 50-cycle timeout, base 0x100).
module tb_rfdc_sync_sequencer;

  localparam logic [19:0] A_NCO = 20'h100;
  localparam logic [19:0] A_GB  = 20'h104;
  localparam logic [19:0] A_PW  = 20'h108;
  localparam logic [19:0] A_BAD = 20'h10C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_ack;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;
  logic        sysref = 1'b0;
  logic        nco_reset;
  logic [3:0]  adc_reset;
  logic [3:0]  dac_reset;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rfdc_sync_sequencer #(
    .NUM_CHANNELS   (4),
    .TIMEOUT_CYCLES (50),
    .BASE_ADDR      (32'h100)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_ctrlport_req_wr      (req_wr),
    .s_ctrlport_req_rd      (req_rd),
    .s_ctrlport_req_addr    (req_addr),
    .s_ctrlport_req_data    (req_data),
    .s_ctrlport_resp_ack    (resp_ack),
    .s_ctrlport_resp_status (resp_status),
    .s_ctrlport_resp_data   (resp_data),
    .sysref_pulse           (sysref),
    .nco_reset              (nco_reset),
    .adc_reset              (adc_reset),
    .dac_reset              (dac_reset)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_write(input string tag, input logic [19:0] addr, input logic [31:0] data,
                            input logic exp_ack);
    req_wr = 1'b1; req_addr = addr; req_data = data;
    cyc();
    req_wr = 1'b0;
    check({tag, "_ack"}, 32'(resp_ack), 32'(exp_ack));
    check({tag, "_wdata0"}, resp_data, 32'h0);
  endtask

  task automatic ctrl_read(input string tag, input logic [19:0] addr, input logic exp_ack,
                           input logic [31:0] exp_data);
    req_rd = 1'b1; req_addr = addr;
    cyc();
    req_rd = 1'b0;
    check({tag, "_ack"}, 32'(resp_ack), 32'(exp_ack));
    check({tag, "_data"}, resp_data, exp_data);
  endtask

  task automatic pulse_sysref();
    sysref = 1'b1;
    cyc();
    sysref = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    check("rst_nco", 32'(nco_reset), 32'h0);
    check("rst_adc", 32'(adc_reset), 32'h0);
    check("rst_dac", 32'(dac_reset), 32'h0);
    check("rst_ack", 32'(resp_ack), 32'h0);
    check("rst_status", 32'(resp_status), 32'h0);
    rst = 1'b0;
    cyc();
    ctrl_read("rd_rst_nco", A_NCO, 1'b1, 32'h0);

    // NCO sequence, SYSREF_WAIT=2
    ctrl_write("wr_wait2", A_NCO, 32'h0102_0000, 1'b1);
    ctrl_read("rd_wait2", A_NCO, 1'b1, 32'h0002_0000);
    ctrl_write("wr_wait_noen", A_NCO, 32'h0007_0000, 1'b1);  // bit24 clear: not stored
    ctrl_read("rd_wait_noen", A_NCO, 1'b1, 32'h0002_0000);
    sysref = 1'b1;                                            // not counted
    ctrl_write("wr_start", A_NCO, 32'h0000_0001, 1'b1);
    sysref = 1'b0;
    repeat (9) cyc();
    pulse_sysref();                                           // 1st
    check("nco_after_sr1", 32'(nco_reset), 32'h0);
    ctrl_write("wr_start_busy", A_NCO, 32'h0100_0001, 1'b1);  // ignored start, wait=0 stored
    ctrl_read("rd_busy", A_NCO, 1'b1, 32'h0000_0001);
    repeat (7) cyc();
    pulse_sysref();                                           // 2nd
    check("nco_after_sr2", 32'(nco_reset), 32'h0);
    repeat (9) cyc();
    pulse_sysref();                                           // 3rd
    check("nco_after_sr3", 32'(nco_reset), 32'h1);
    repeat (9) cyc();
    check("nco_hold", 32'(nco_reset), 32'h1);
    pulse_sysref();                                           // 4th
    check("nco_after_sr4", 32'(nco_reset), 32'h0);
    cyc();
    ctrl_read("rd_done", A_NCO, 1'b1, 32'h0000_0002);

    // Timeout: START with wait=5, no SYSREF
    ctrl_write("wr_start_tmo", A_NCO, 32'h0105_0001, 1'b1);
    repeat (49) cyc();
    check("tmo_nco", 32'(nco_reset), 32'h0);
    ctrl_read("rd_tmo_49", A_NCO, 1'b1, 32'h0005_0001);
    ctrl_read("rd_tmo_50", A_NCO, 1'b1, 32'h0005_0100);
    check("tmo_nco_after", 32'(nco_reset), 32'h0);

    // Undecoded addresses
    ctrl_write("wr_bad", A_BAD, 32'h0000_0001, 1'b0);
    ctrl_read("rd_bad", A_BAD, 1'b0, 32'h0);
    ctrl_write("wr_base_miss", 20'h000, 32'h0000_0001, 1'b0);
    ctrl_read("rd_after_bad", A_NCO, 1'b1, 32'h0005_0100);

    // rd+wr together: write wins, single ack
    req_wr = 1'b1; req_rd = 1'b1; req_addr = A_PW; req_data = 32'h5;
    cyc();
    req_wr = 1'b0; req_rd = 1'b0;
    check("both_ack", 32'(resp_ack), 32'h1);
    check("both_data", resp_data, 32'h0);
    cyc();
    check("both_ack_once", 32'(resp_ack), 32'h0);
    ctrl_read("rd_pw5", A_PW, 1'b1, 32'h5);

    // Gearbox pulses, W=3
    ctrl_write("wr_pw3", A_PW, 32'h3, 1'b1);
    ctrl_write("wr_gb", A_GB, 32'h0002_0001, 1'b1);
    check("gb_c1_adc", 32'(adc_reset), 32'h1);
    check("gb_c1_dac", 32'(dac_reset), 32'h2);
    ctrl_read("rd_gb", A_GB, 1'b1, 32'h0002_0001);
    cyc();
    check("gb_c3_adc", 32'(adc_reset), 32'h1);
    cyc();
    check("gb_c4_adc", 32'(adc_reset), 32'h1);
    check("gb_c4_dac", 32'(dac_reset), 32'h2);
    cyc();
    check("gb_end_adc", 32'(adc_reset), 32'h0);
    check("gb_end_dac", 32'(dac_reset), 32'h0);

    // Re-request in pulse cycle 2
    ctrl_write("wr_gb_a", A_GB, 32'h0000_0001, 1'b1);
    cyc();
    ctrl_write("wr_gb_b", A_GB, 32'h0000_0001, 1'b1);
    check("rr_c3", 32'(adc_reset), 32'h1);
    cyc();
    check("rr_c4", 32'(adc_reset), 32'h1);
    cyc();
    check("rr_c5", 32'(adc_reset), 32'h1);
    cyc();
    check("rr_c6", 32'(adc_reset), 32'h1);
    cyc();
    check("rr_end", 32'(adc_reset), 32'h0);

    // W=0: single-cycle pulse
    ctrl_write("wr_pw0", A_PW, 32'h0, 1'b1);
    ctrl_write("wr_gb_d3", A_GB, 32'h0008_0000, 1'b1);
    check("w0_c1", 32'(dac_reset), 32'h8);
    cyc();
    check("w0_end", 32'(dac_reset), 32'h0);

    // rst during nco_reset=1 and active pulses
    ctrl_write("wr_pw15", A_PW, 32'hF, 1'b1);
    ctrl_write("wr_start0", A_NCO, 32'h0100_0001, 1'b1);
    cyc();
    pulse_sysref();
    check("nco_wait0", 32'(nco_reset), 32'h1);
    ctrl_write("wr_gb_all", A_GB, 32'h000F_000F, 1'b1);
    check("gb_all_adc", 32'(adc_reset), 32'hF);
    rst = 1'b1;
    cyc();
    check("rst_mid_nco", 32'(nco_reset), 32'h0);
    check("rst_mid_adc", 32'(adc_reset), 32'h0);
    check("rst_mid_dac", 32'(dac_reset), 32'h0);
    rst = 1'b0;
    ctrl_read("rd_rst2_nco", A_NCO, 1'b1, 32'h0);
    ctrl_read("rd_rst2_pw", A_PW, 1'b1, 32'h0);
    ctrl_read("rd_rst2_gb", A_GB, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
